// File: rtl/tl_ul_sram_responder_if.sv
// TL-UL A/D channel bundle between a requester (master) and the SRAM
// responder (slave). Clock and reset are kept outside the bundle.
interface tl_ul_sram_responder_if #(
  parameter int SOURCE_W = 3
);
  // A channel: request
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [1:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [31:0]         a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;

  // D channel: response
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [1:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic [31:0]         d_data;
  logic                d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TL-UL manager terminating 32-bit A-channel requests against a local
// word-addressed store. One response register, one-cycle latency, and a
// new request may be taken in the same cycle the held response drains.
module tl_ul_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          SOURCE_W    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ul_sram_responder_if.slave  bus
);

  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW = 32'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_ARITH       = 3'd2,
    OP_LOGICAL     = 3'd3,
    OP_GET         = 3'd4,
    OP_HINT        = 3'd5
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACK      = 3'd0,
    D_ACK_DATA = 3'd1,
    D_HINT_ACK = 3'd2
  } d_op_e;

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    d_op_e               opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
    logic                corrupt;
  } rsp_t;

  state_e           state_q, state_d;
  rsp_t             rsp_q, rsp_d;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             aligned;
  logic             access_ok;
  logic             wr_en;
  logic             d_valid;
  logic             a_fire;
  logic             d_fire;
  logic             unused_a_param;

  // The window is aligned to its own size, so an unsigned offset compare
  // covers both the lower and upper bound (addresses below wrap high).
  assign offset    = bus.a_address - BASE_ADDR;
  assign idx       = offset[IDX_W+1:2];
  assign in_range  = (offset < WINDOW);
  assign access_ok = in_range && aligned;

  assign d_valid     = (state_q == FULL);
  assign bus.a_ready = !d_valid || bus.d_ready;
  assign a_fire      = bus.a_valid && bus.a_ready;
  assign d_fire      = d_valid && bus.d_ready;

  assign bus.d_valid   = d_valid;
  assign bus.d_opcode  = rsp_q.opcode;
  assign bus.d_param   = 2'd0;
  assign bus.d_size    = rsp_q.size;
  assign bus.d_source  = rsp_q.source;
  assign bus.d_denied  = rsp_q.denied;
  assign bus.d_data    = rsp_q.data;
  assign bus.d_corrupt = rsp_q.corrupt;

  assign unused_a_param = ^bus.a_param;

  // Size legality and natural alignment of the request address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    aligned = 1'b0;
    case (bus.a_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !bus.a_address[0];
      2'd2:    aligned = (bus.a_address[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Build the response for the beat on the A channel and decide the write.
  always_comb begin
    rsp_d         = '0;
    rsp_d.opcode  = D_ACK;
    rsp_d.size    = bus.a_size;
    rsp_d.source  = bus.a_source;
    wr_en         = 1'b0;
    case (a_op_e'(bus.a_opcode))
      OP_PUT_FULL, OP_PUT_PARTIAL: begin
        rsp_d.denied = !access_ok;
        wr_en        = a_fire && access_ok;
      end
      OP_GET: begin
        rsp_d.opcode = D_ACK_DATA;
        if (access_ok) begin
          rsp_d.data = mem[idx];
        end else begin
          rsp_d.denied  = 1'b1;
          rsp_d.corrupt = 1'b1;
        end
      end
      OP_ARITH, OP_LOGICAL: begin
        rsp_d.opcode  = D_ACK_DATA;
        rsp_d.denied  = 1'b1;
        rsp_d.corrupt = 1'b1;
      end
      OP_HINT: begin
        rsp_d.opcode = D_HINT_ACK;
        rsp_d.denied = !in_range;
      end
      default: begin
        rsp_d.denied = 1'b1;
      end
    endcase
  end

  // Response-slot state register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Slot fills on every accepted request and empties when drained alone.
  always_comb begin
    state_d = state_q;
    if (a_fire)      state_d = FULL;
    else if (d_fire) state_d = EMPTY;
  end

  // Response payload: captured on accept, otherwise held stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       rsp_q <= '0;
    else if (a_fire) rsp_q <= rsp_d;
  end

  // Byte-lane writes into the word store.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; contents survive reset and are
    // undefined after power-up, which keeps it mappable onto plain flops/RAM.
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.a_mask[i]) mem[idx][8*i +: 8] <= bus.a_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Randomised scoreboard bench for tl_ul_sram_responder: a byte-array model
// predicts each response at accept time; an independent monitor compares
// whatever the D channel presents against the queue head.
module tb_tl_ul_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          SW    = 3;

  typedef struct {
    logic [2:0]    op;
    logic [1:0]    size;
    logic [SW-1:0] src;
    logic          denied;
    logic [31:0]   data;
    logic          corrupt;
    int            cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tl_ul_sram_responder_if #(.SOURCE_W(SW)) bus ();

  tl_ul_sram_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .SOURCE_W   (SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  exp_t       sb[$];
  logic [7:0] ref_mem [4*DEPTH];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         front_seen = 1'b0;
  bit         rand_mode = 1'b0;
  logic       d_ready_ctl = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: address window, alignment and opcode rules over a byte array.
  task automatic predict(input logic [2:0] op, input logic [1:0] size, input logic [SW-1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    exp_t   e;
    longint a = longint'(addr);
    bit     in_range = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    bit     shape_ok = (size != 2'd3) && ((addr % (32'd1 << size)) == 0);
    bit     ok = in_range && shape_ok;
    int     w = int'((a - longint'(BASE)) & ~longint'(3));
    e.size = size; e.src = src; e.data = '0; e.corrupt = 1'b0; e.cyc = cyc + 1;
    case (op)
      3'd0, 3'd1: begin
        e.op = 3'd0; e.denied = !ok;
        if (ok) for (int i = 0; i < 4; i++) if (mask[i]) ref_mem[w+i] = data[8*i +: 8];
      end
      3'd4: begin
        e.op = 3'd1; e.denied = !ok; e.corrupt = !ok;
        if (ok) e.data = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      end
      3'd2, 3'd3: begin e.op = 3'd1; e.denied = 1'b1; e.corrupt = 1'b1; end
      3'd5:       begin e.op = 3'd2; e.denied = !in_range; end
      default:    begin e.op = 3'd0; e.denied = 1'b1; end
    endcase
    sb.push_back(e);
  endtask

  task automatic go_edge(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [SW-1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    bit done = 1'b0;
    bus.a_valid = 1'b1; bus.a_opcode = op; bus.a_param = 3'($urandom); bus.a_size = size;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask; bus.a_data = data;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (bus.a_ready) begin
        predict(op, size, src, addr, mask, data);
        done = 1'b1;
      end
      @(posedge clock); #2;
    end
    check("accept", 32'(done), 32'd1);
    bus.a_valid = 1'b0;
  endtask

  initial forever begin @(posedge clock); cyc++; end

  // Sole driver of d_ready: fixed level or random back-pressure.
  initial begin
    bus.d_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      bus.d_ready = rand_mode ? ($urandom_range(0, 3) != 0) : d_ready_ctl;
    end
  end

  // Monitor: compare presented responses to the queue head, away from the edge.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("a_ready_rule", 32'(bus.a_ready), 32'(!bus.d_valid || bus.d_ready));
      if (bus.d_valid) begin
        if (sb.size() == 0) begin
          check("stale_response", 32'(bus.d_valid), 32'd0);
        end else begin
          check("d_opcode",  32'(bus.d_opcode),  32'(sb[0].op));
          check("d_source",  32'(bus.d_source),  32'(sb[0].src));
          check("d_size",    32'(bus.d_size),    32'(sb[0].size));
          check("d_denied",  32'(bus.d_denied),  32'(sb[0].denied));
          check("d_corrupt", 32'(bus.d_corrupt), 32'(sb[0].corrupt));
          check("d_data",    bus.d_data,         sb[0].data);
          check("d_param",   32'(bus.d_param),   32'd0);
          if (!front_seen) check("latency", 32'(cyc), 32'(sb[0].cyc));
          front_seen = 1'b1;
          if (bus.d_ready) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_valid"},   32'(bus.d_valid),   32'd0);
    check({tag, "_a_ready"},   32'(bus.a_ready),   32'd1);
    check({tag, "_d_opcode"},  32'(bus.d_opcode),  32'd0);
    check({tag, "_d_size"},    32'(bus.d_size),    32'd0);
    check({tag, "_d_source"},  32'(bus.d_source),  32'd0);
    check({tag, "_d_denied"},  32'(bus.d_denied),  32'd0);
    check({tag, "_d_data"},    bus.d_data,         32'd0);
    check({tag, "_d_corrupt"}, 32'(bus.d_corrupt), 32'd0);
  endtask

  initial begin
    int t0;
    bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
    bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;

    #12;
    check_reset_outputs("por");
    go_edge(1);
    reset = 1'b0;

    // Fill the store; the first Put lands on the first edge after reset release.
    for (int w = 0; w < DEPTH; w++)
      send(3'd0, 2'd2, SW'(w), BASE + 32'(4 * w), 4'hF, $urandom);

    // Directed: full write then read, partial write, out-of-range, bad shapes.
    send(3'd0, 2'd2, 3'd5, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    send(3'd4, 2'd2, 3'd5, BASE + 32'h10, 4'hF, 32'h0);
    send(3'd1, 2'd2, 3'd1, BASE + 32'h10, 4'h2, 32'h0000_5500);
    send(3'd4, 2'd2, 3'd2, BASE + 32'h10, 4'h0, 32'h0);
    send(3'd4, 2'd2, 3'd3, BASE + 32'h100, 4'hF, 32'h0);
    send(3'd0, 2'd2, 3'd4, 32'h7FFF_FFFC, 4'hF, 32'h1234_5678);
    send(3'd4, 2'd2, 3'd4, BASE + 32'hFC, 4'hF, 32'h0);
    send(3'd4, 2'd2, 3'd6, BASE + 32'h2, 4'hF, 32'h0);
    send(3'd2, 2'd2, 3'd7, BASE, 4'hF, 32'h0);
    send(3'd4, 2'd1, 3'd0, BASE + 32'h6, 4'h3, 32'h0);
    send(3'd0, 2'd3, 3'd1, BASE + 32'h8, 4'hF, 32'hFFFF_FFFF);
    send(3'd5, 2'd2, 3'd2, BASE + 32'h4, 4'hF, 32'h0);
    send(3'd6, 2'd2, 3'd3, BASE + 32'h4, 4'hF, 32'h0);
    send(3'd7, 2'd2, 3'd4, BASE + 32'h4, 4'hF, 32'h0);
    send(3'd4, 2'd2, 3'd5, BASE + 32'h8, 4'hF, 32'h0);

    // Back-pressure: response held three cycles, next request blocked.
    go_edge(2);
    d_ready_ctl = 1'b0;
    go_edge(1);
    send(3'd4, 2'd2, 3'd1, BASE + 32'h10, 4'hF, 32'h0);
    fork
      begin
        repeat (3) begin
          @(negedge clock);
          check("stall_a_ready", 32'(bus.a_ready), 32'd0);
        end
        d_ready_ctl = 1'b1;
      end
      send(3'd4, 2'd2, 3'd2, BASE + 32'h14, 4'hF, 32'h0);
    join

    // Eight back-to-back Gets under continuous d_ready.
    t0 = cyc;
    for (int s = 0; s < 8; s++)
      send(3'd4, 2'd2, SW'(s), BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 4'hF, 32'h0);
    check("b2b_cycles", 32'(cyc - t0), 32'd8);

    // Async reset with a response pending.
    go_edge(2);
    d_ready_ctl = 1'b0;
    go_edge(1);
    send(3'd4, 2'd2, 3'd6, BASE + 32'h20, 4'hF, 32'h0);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    sb.delete();
    front_seen = 1'b0;
    go_edge(2);
    reset = 1'b0;
    d_ready_ctl = 1'b1;
    go_edge(3);
    check("post_rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
    send(3'd4, 2'd2, 3'd7, BASE + 32'h10, 4'hF, 32'h0);

    // Randomised traffic with random back-pressure and idle gaps.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int          r  = $urandom_range(0, 99);
      int          sz = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
      logic [2:0]  op;
      logic [31:0] addr;
      int          lo;
      if      (r < 35) op = 3'd4;
      else if (r < 60) op = 3'd0;
      else if (r < 80) op = 3'd1;
      else if (r < 85) op = 3'd2;
      else if (r < 88) op = 3'd3;
      else if (r < 94) op = 3'd5;
      else             op = (r < 97) ? 3'd6 : 3'd7;
      if (op == 3'd5) sz = $urandom_range(0, 2);
      lo = $urandom_range(0, 3) & ~((1 << sz) - 1);
      if (op != 3'd5 && $urandom_range(0, 7) == 0) lo = $urandom_range(0, 3);
      case ($urandom_range(0, 19))
        0:       addr = BASE - 32'(4 * $urandom_range(1, 8)) + 32'(lo);
        1:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8)) + 32'(lo);
        2:       addr = $urandom;
        default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'(lo);
      endcase
      send(op, 2'(sz), SW'($urandom), addr, 4'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) go_edge($urandom_range(1, 2));
    end
    rand_mode = 1'b0;
    d_ready_ctl = 1'b1;
    go_edge(6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
